seq_div: RTL and testbench

- Iterative signed divider; the inverse of the team's Booth radix-2 multiplier.
- Takes a double-width product-style dividend and a single-width divisor.
- Returns quotient and remainder through valid/ready handshakes on both sides.
- Sits in the arithmetic datapath next to the multiplier; one operation in flight at a time.

---
 rtl/seq_div.sv | 177 +++++++++++++++++
 tb/tb_seq_div.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// seq_div: iterative restoring divider, 2*WIDTH-bit dividend over WIDTH-bit divisor, valid/ready on both sides.
// Build option: define SEQ_DIV_SIGNED_EN for two's-complement operands; unsigned otherwise.
module seq_div #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [WIDTH-1:0]  rem_reg, rem_next;
    logic [DW-1:0]     quo_reg, quo_next;
    logic [WIDTH:0]    dvs_reg, dvs_next;
    logic              in_ready_reg, in_ready_next;
    logic [WIDTH-1:0]  quotient_reg, quotient_next;
    logic [WIDTH-1:0]  remainder_reg, remainder_next;
    logic              dbz_reg, dbz_next;
    logic              ovf_reg, ovf_next;

    logic [DW-1:0]     dvd_mag;
    logic [WIDTH:0]    dvs_mag;
    logic [WIDTH:0]    shifted;
    logic [WIDTH-1:0]  fix_quo;
    logic [WIDTH-1:0]  fix_rem;
    logic              fix_ovf;

`ifdef SEQ_DIV_SIGNED_EN
    logic              qneg_reg, qneg_next;
    logic              rneg_reg, rneg_next;
    logic [WIDTH:0]    dvs_ext;
    logic [DW:0]       signed_quo;

    // Magnitudes are taken one bit wider than the operand so the most negative value survives negation.
    assign dvs_ext    = {divisor[WIDTH-1], divisor};
    assign dvd_mag    = dividend[DW-1] ? -dividend : dividend;
    assign dvs_mag    = divisor[WIDTH-1] ? -dvs_ext : dvs_ext;
    assign signed_quo = qneg_reg ? -{1'b0, quo_reg} : {1'b0, quo_reg};
    assign fix_quo    = signed_quo[WIDTH-1:0];
    assign fix_rem    = rneg_reg ? -rem_reg : rem_reg;
    // The quotient fits only if every bit above the sign position matches it.
    assign fix_ovf    = !((&signed_quo[DW:WIDTH-1]) || !(|signed_quo[DW:WIDTH-1]));
`else
    assign dvd_mag = dividend;
    assign dvs_mag = {1'b0, divisor};
    assign fix_quo = quo_reg[WIDTH-1:0];
    assign fix_rem = rem_reg;
    assign fix_ovf = |quo_reg[DW-1:WIDTH];
`endif

    assign shifted = {rem_reg, quo_reg[DW-1]};

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        dvs_next       = dvs_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        ovf_next       = ovf_reg;
`ifdef SEQ_DIV_SIGNED_EN
        qneg_next      = qneg_reg;
        rneg_next      = rneg_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    if (divisor == '0) begin
                        quotient_next  = '1;
                        remainder_next = dividend[WIDTH-1:0];
                        dbz_next       = 1'b1;
                        ovf_next       = 1'b0;
                        state_next     = DONE;
                    end else begin
                        rem_next   = '0;
                        quo_next   = dvd_mag;
                        dvs_next   = dvs_mag;
                        count_next = '0;
                        dbz_next   = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                        qneg_next  = dividend[DW-1] ^ divisor[WIDTH-1];
                        rneg_next  = dividend[DW-1];
`endif
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                // The partial remainder stays below the divisor, so it always fits back into WIDTH bits.
                if (shifted >= dvs_reg) begin
                    rem_next = WIDTH'(shifted - dvs_reg);
                    quo_next = {quo_reg[DW-2:0], 1'b1};
                end else begin
                    rem_next = shifted[WIDTH-1:0];
                    quo_next = {quo_reg[DW-2:0], 1'b0};
                end
                count_next = count_reg + 1'b1;
                if (count_reg == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                quotient_next  = fix_quo;
                remainder_next = fix_rem;
                ovf_next       = fix_ovf;
                state_next     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        in_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            in_ready_reg  <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_reg      <= 1'b0;
            rneg_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            dvs_reg       <= dvs_next;
            in_ready_reg  <= in_ready_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
            ovf_reg       <= ovf_next;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_reg      <= qneg_next;
            rneg_reg      <= rneg_next;
`endif
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed vectors for seq_div at WIDTH=4; expected values cover both the signed and unsigned builds.
module tb_seq_div;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       dividend;
    logic [3:0]       divisor;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       quotient;
    logic [3:0]       remainder;
    logic             div_by_zero;
    logic             overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    seq_div #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start an operation from posedge+1 and return once the accepting edge has passed.
    task automatic start_op(input logic [7:0] dvd, input logic [3:0] dvs);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("in_ready_before_op", in_ready, 1'b1);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                          input logic [3:0] exp_q, input logic [3:0] exp_r,
                          input logic exp_dbz, input logic exp_ovf,
                          input int exp_lat, input int hold);
        int edges;
        start_op(dvd, dvs);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        $display("op %s: %02h / %01h -> q=%01h r=%01h dbz=%0b ovf=%0b after %0d edges",
                 tag, dvd, dvs, quotient, remainder, div_by_zero, overflow, edges);
        check({tag, "_latency"}, edges, exp_lat);
        check({tag, "_quotient"}, quotient, exp_q);
        check({tag, "_remainder"}, remainder, exp_r);
        check({tag, "_div_by_zero"}, div_by_zero, exp_dbz);
        check({tag, "_overflow"}, overflow, exp_ovf);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_quotient"}, quotient, exp_q);
            check({tag, "_hold_remainder"}, remainder, exp_r);
            check({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_dropped"}, out_valid, 1'b0);
        check({tag, "_in_ready_after"}, in_ready, 1'b1);
    endtask

    typedef struct {
        string      tag;
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [3:0] q;
        logic [3:0] r;
        logic       ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int seen_valid;
`ifdef SEQ_DIV_SIGNED_EN
        vecs[0] = '{"20_by_3",    8'h14, 4'h3, 4'h6, 4'h2, 1'b0};
        vecs[1] = '{"m7_by_2",    8'hF9, 4'h2, 4'hD, 4'hF, 1'b0};
        vecs[2] = '{"m16_by_2",   8'hF0, 4'h2, 4'h8, 4'h0, 1'b0};
        vecs[3] = '{"100_by_3",   8'h64, 4'h3, 4'h1, 4'h1, 1'b1};
        vecs[4] = '{"20_by_m3",   8'h14, 4'hD, 4'hA, 4'h2, 1'b0};
        vecs[5] = '{"m128_by_m8", 8'h80, 4'h8, 4'h0, 4'h0, 1'b1};
        vecs[6] = '{"7_by_m2",    8'h07, 4'hE, 4'hD, 4'h1, 1'b0};
`else
        vecs[0] = '{"20_by_3",    8'h14, 4'h3, 4'h6, 4'h2, 1'b0};
        vecs[1] = '{"249_by_2",   8'hF9, 4'h2, 4'hC, 4'h1, 1'b1};
        vecs[2] = '{"240_by_2",   8'hF0, 4'h2, 4'h8, 4'h0, 1'b1};
        vecs[3] = '{"100_by_3",   8'h64, 4'h3, 4'h1, 4'h1, 1'b1};
        vecs[4] = '{"20_by_13",   8'h14, 4'hD, 4'h1, 4'h7, 1'b0};
        vecs[5] = '{"128_by_8",   8'h80, 4'h8, 4'h0, 4'h0, 1'b1};
        vecs[6] = '{"7_by_14",    8'h07, 4'hE, 4'h0, 4'h7, 1'b0};
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2;
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_quotient", quotient, 4'h0);
        check("reset_flags", {div_by_zero, overflow}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].tag, vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, 1'b0, vecs[i].ovf, 10, 0);
        end
        run_op("div_by_zero", 8'h5A, 4'h0, 4'hF, 4'hA, 1'b1, 1'b0, 1, 0);

        // Backpressure in DONE, then an immediate second operation.
        run_op("hold", vecs[0].dvd, vecs[0].dvs, vecs[0].q, vecs[0].r, 1'b0, vecs[0].ovf, 10, 5);
        run_op("back_to_back", vecs[1].dvd, vecs[1].dvs, vecs[1].q, vecs[1].r, 1'b0, vecs[1].ovf, 10, 0);

        // Asynchronous reset in the middle of CALC.
        start_op(8'h14, 4'h3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", in_ready, 1'b0);
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_quotient", quotient, 4'h0);
        check("midreset_remainder", remainder, 4'h0);
        check("midreset_flags", {div_by_zero, overflow}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", in_ready, 1'b1);
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        check("post_reset_no_stale_valid", seen_valid, 0);
        run_op("after_reset", vecs[3].dvd, vecs[3].dvs, vecs[3].q, vecs[3].r, 1'b0, vecs[3].ovf, 10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
